mem_bus_arbiter: RTL

- Sequences and shares the single memory/IO bus between two bus masters.
- Requester 0 is the LEGv8 CPU. Requester 1 is the program loader/DMA port.
- Grants the bus round-robin and runs one fixed-length access at a time with WAIT_STATES cycles.
- Drives the memory address, write data and strobes. At top level, mem_drive enables the tristate data bus.

---
 rtl/mem_bus_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Round-robin arbiter and access sequencer for the shared
//               memory/IO bus. Requester 0 is the CPU and requester 1 is the
//               loader/DMA port. One fixed-length access runs at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic              clock,
    input  logic              reset,
    // requester 0 (CPU)
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    // requester 1 (loader / DMA)
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    // read return
    output logic [DATA_W-1:0] rdata,
    // memory bus
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_drive,
    output logic              mem_we,
    output logic              mem_oe,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic              busy,
    output logic              owner
);

    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_ACCESS = 2'd1;
    localparam logic [1:0] C_DONE   = 2'd2;

    // The counter holds the remaining ACCESS cycles minus one.
    localparam logic [3:0] C_CNT_LOAD = 4'(WAIT_STATES - 1);

    // Catch an out-of-range wait-state setting at elaboration time.
    if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("mem_bus_arbiter: WAIT_STATES must be in 1..15");
    end

    logic [1:0]        state_q,      state_d;
    logic [3:0]        cnt_q,        cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q,      owner_d;
    logic              write_q,      write_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic [DATA_W-1:0] rdata_q,      rdata_d;

    logic              w_any_valid;
    logic              w_grant_sel;

    // Pick the winner: a lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        w_any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant_sel = ~last_grant_q;
        end else begin
            w_grant_sel = req1_valid;
        end
    end

    // Next-state logic: grant in IDLE, count down in ACCESS, one-cycle DONE.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;

        case (state_q)
            C_IDLE: begin
                if (w_any_valid) begin
                    owner_d      = w_grant_sel;
                    last_grant_d = w_grant_sel;
                    write_d      = w_grant_sel ? req1_write : req0_write;
                    addr_d       = w_grant_sel ? req1_addr  : req0_addr;
                    wdata_d      = w_grant_sel ? req1_wdata : req0_wdata;
                    cnt_d        = C_CNT_LOAD;
                    state_d      = C_ACCESS;
                end
            end
            C_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Memory data is sampled on the last ACCESS cycle only.
                    if (!write_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = C_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            C_DONE: begin
                state_d = C_IDLE;
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    // State registers; last grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= C_IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    // Strobes, completion pulses and status decode straight from state.
    always_comb begin
        mem_we     = (state_q == C_ACCESS) &  write_q;
        mem_oe     = (state_q == C_ACCESS) & ~write_q;
        mem_drive  = mem_we;
        req0_ready = (state_q == C_DONE) & ~owner_q;
        req1_ready = (state_q == C_DONE) &  owner_q;
        busy       = (state_q == C_ACCESS) | (state_q == C_DONE);
        owner      = owner_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        rdata      = rdata_q;
    end

endmodule
`default_nettype wire
